// File: rtl/pipe_phase_acc_if.sv
// Step-request / phase-result bundle for pipe_phase_acc.
interface pipe_phase_acc_if #(
    parameter int W = 32
);
    logic         en;
    logic         clr;
    logic [W-1:0] fcw;
    logic [W-1:0] init;
    logic [W-1:0] phase;
    logic         valid;
    logic         wrap;

    modport master (
        output en, clr, fcw, init,
        input  phase, valid, wrap
    );

    modport slave (
        input  en, clr, fcw, init,
        output phase, valid, wrap
    );
endinterface

// File: rtl/pipe_phase_acc.sv
// Carry-segmented pipelined phase accumulator: segment k adds k cycles after
// capture, and output deskew realigns all segments to a latency of NSEG.
module pipe_phase_acc #(
    parameter int W   = 32,
    parameter int SEG = 8
) (
    input  logic            clk,
    input  logic            reset,
    pipe_phase_acc_if.slave bus
);
    localparam int NSEG = (SEG >= 1) ? (W / SEG) : 1;

    if (SEG < 1) begin : g_cfg_seg
        $error("pipe_phase_acc: SEG must be >= 1");
    end else if ((W % SEG) != 0) begin : g_cfg_div
        $error("pipe_phase_acc: W must be a multiple of SEG");
    end

    logic            step;
    logic [NSEG-1:0] step_sr;
    logic [NSEG-1:0] clr_sr;

    assign step = bus.en | bus.clr;

    // Bit i holds the step/clr qualifier delayed by i+1 cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_sr <= '0;
            clr_sr  <= '0;
        end else begin
            step_sr <= NSEG'({step_sr, step});
            clr_sr  <= NSEG'({clr_sr, bus.clr});
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        localparam int D = NSEG - 1 - k;

        logic [SEG-1:0] f_k;
        logic [SEG-1:0] i_k;
        logic           st_k;
        logic           cl_k;
        logic           ci_k;
        logic [SEG-1:0] acc;
        logic           cy;
        logic [SEG:0]   sum;
        logic [SEG-1:0] out_k;

        if (k == 0) begin : g_in
            assign f_k  = bus.fcw[SEG-1:0];
            assign i_k  = bus.init[SEG-1:0];
            assign st_k = step;
            assign cl_k = bus.clr;
            assign ci_k = 1'b0;
        end else begin : g_in
            logic [k-1:0][SEG-1:0] f_sk;
            logic [k-1:0][SEG-1:0] i_sk;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    f_sk <= '0;
                    i_sk <= '0;
                end else begin
                    f_sk <= (k*SEG)'({f_sk, bus.fcw[k*SEG +: SEG]});
                    i_sk <= (k*SEG)'({i_sk, bus.init[k*SEG +: SEG]});
                end
            end

            assign f_k  = f_sk[k-1];
            assign i_k  = i_sk[k-1];
            assign st_k = step_sr[k-1];
            assign cl_k = clr_sr[k-1];
            assign ci_k = g_seg[k-1].cy;
        end

        assign sum = {1'b0, acc} + {1'b0, f_k} + {{SEG{1'b0}}, ci_k};

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc <= '0;
                cy  <= 1'b0;
            end else if (st_k) begin
                acc <= cl_k ? i_k : sum[SEG-1:0];
                cy  <= cl_k ? 1'b0 : sum[SEG];
            end
        end

        if (D == 0) begin : g_out
            assign out_k = acc;
        end else begin : g_out
            logic [D-1:0][SEG-1:0] ds;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ds <= '0;
                end else begin
                    ds <= (D*SEG)'({ds, acc});
                end
            end

            assign out_k = ds[D-1];
        end

        assign bus.phase[k*SEG +: SEG] = out_k;
    end

    // The last segment's carry already reads 0 for a clr step; the clr term
    // only makes the intent explicit.
    assign bus.valid = step_sr[NSEG-1];
    assign bus.wrap  = step_sr[NSEG-1] & ~clr_sr[NSEG-1] & g_seg[NSEG-1].cy;
endmodule

// File: tb/tb_pipe_phase_acc.sv
// Directed bench for pipe_phase_acc at W=16, SEG=4 (latency 4).
module tb_pipe_phase_acc;
    localparam int W   = 16;
    localparam int SEG = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ghost    = 0;

    pipe_phase_acc_if #(.W(W)) bus ();

    pipe_phase_acc #(.W(W), .SEG(SEG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [W-1:0] p, input logic w);
        check({tag, ".valid"}, 32'(bus.valid), 32'(v));
        check({tag, ".phase"}, 32'(bus.phase), 32'(p));
        check({tag, ".wrap"},  32'(bus.wrap),  32'(w));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_in(input logic e, input logic c, input logic [W-1:0] f, input logic [W-1:0] i);
        bus.en   = e;
        bus.clr  = c;
        bus.fcw  = f;
        bus.init = i;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) step_in(1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
    endtask

    initial begin
        bus.en   = 1'b0;
        bus.clr  = 1'b0;
        bus.fcw  = '0;
        bus.init = '0;
        tick();
        tick();
        check_out("reset", 1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        tick();
        check_out("release", 1'b0, 16'h0000, 1'b0);

        // clr load and latency
        step_in(1'b0, 1'b1, 16'h0000, 16'h1234);
        idle(2);
        check("clr_early.valid", 32'(bus.valid), 32'd0);
        idle(1);
        check_out("clr", 1'b1, 16'h1234, 1'b0);
        idle(1);
        check_out("clr_hold", 1'b0, 16'h1234, 1'b0);

        // back-to-back increments
        step_in(1'b1, 1'b0, 16'h0001, 16'h0000);
        step_in(1'b1, 1'b0, 16'h0001, 16'h0000);
        step_in(1'b1, 1'b0, 16'h0001, 16'h0000);
        idle(1);
        check_out("inc0", 1'b1, 16'h1235, 1'b0);
        idle(1);
        check_out("inc1", 1'b1, 16'h1236, 1'b0);
        idle(1);
        check_out("inc2", 1'b1, 16'h1237, 1'b0);
        idle(1);
        check_out("inc_hold", 1'b0, 16'h1237, 1'b0);

        // carry ripple and wrap, interleaved with reloads
        step_in(1'b0, 1'b1, 16'h0000, 16'h0FFF);
        step_in(1'b1, 1'b0, 16'h0001, 16'h0000);
        step_in(1'b0, 1'b1, 16'h0000, 16'hFFFF);
        step_in(1'b1, 1'b0, 16'h0001, 16'h0000);
        check_out("rip_ld0", 1'b1, 16'h0FFF, 1'b0);
        idle(1);
        check_out("rip0", 1'b1, 16'h1000, 1'b0);
        idle(1);
        check_out("rip_ld1", 1'b1, 16'hFFFF, 1'b0);
        idle(1);
        check_out("rip_wrap", 1'b1, 16'h0000, 1'b1);
        idle(1);
        check_out("rip_hold", 1'b0, 16'h0000, 1'b0);

        // clr has priority over en; multi-segment wrap
        step_in(1'b1, 1'b1, 16'h1111, 16'hFFF0);
        step_in(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(2);
        check_out("prio", 1'b1, 16'hFFF0, 1'b0);
        idle(1);
        check_out("prio_wrap", 1'b1, 16'h0010, 1'b1);

        // adjacent words must not mix across segments
        step_in(1'b0, 1'b1, 16'h0000, 16'h0000);
        step_in(1'b1, 1'b0, 16'h0F00, 16'h0000);
        step_in(1'b1, 1'b0, 16'h0100, 16'h0000);
        step_in(1'b1, 1'b0, 16'h00FF, 16'h0000);
        check_out("alt_ld", 1'b1, 16'h0000, 1'b0);
        idle(1);
        check_out("alt0", 1'b1, 16'h0F00, 1'b0);
        idle(1);
        check_out("alt1", 1'b1, 16'h1000, 1'b0);
        idle(1);
        check_out("alt2", 1'b1, 16'h10FF, 1'b0);

        // en gap: phase holds, fcw in the gap is ignored
        step_in(1'b0, 1'b1, 16'h0000, 16'h0000);
        step_in(1'b1, 1'b0, 16'h0010, 16'h0000);
        step_in(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        step_in(1'b1, 1'b0, 16'h0010, 16'h0000);
        check_out("gap_ld", 1'b1, 16'h0000, 1'b0);
        idle(1);
        check_out("gap0", 1'b1, 16'h0010, 1'b0);
        idle(1);
        check_out("gap1", 1'b0, 16'h0010, 1'b0);
        idle(1);
        check_out("gap2", 1'b1, 16'h0020, 1'b0);
        idle(1);
        check_out("gap_hold", 1'b0, 16'h0020, 1'b0);

        // reset with steps in flight
        step_in(1'b0, 1'b1, 16'h0000, 16'h5555);
        step_in(1'b1, 1'b0, 16'h0101, 16'h0000);
        idle(1);
        reset = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 16'h0000, 1'b0);
        idle(2);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            if (bus.valid) ghost++;
        end
        check("no_ghost_valid", 32'(ghost), 32'd0);
        check("rst_phase", 32'(bus.phase), 32'h0);
        step_in(1'b1, 1'b0, 16'h0007, 16'h0000);
        idle(3);
        check_out("first_en", 1'b1, 16'h0007, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_phase_acc.md
PIPE_PHASE_ACC -- requirements
Module: pipe_phase_acc

Interface
REQ-001 Parameter W, default 32: accumulator/phase width in bits.
REQ-002 Parameter SEG, default 8: carry-segment width in bits; NSEG = W/SEG pipeline segments.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  advance request: one accumulation step per cycle sampled high.
REQ-006 clr  input  1  synchronous restart: the step sampled with clr=1 loads init.
REQ-007 fcw  input  W  frequency control word, sampled in the same cycle as en.
REQ-008 init  input  W  restart phase, sampled in the same cycle as clr.
REQ-009 phase  output  W  accumulated phase, all segments time-aligned.
REQ-010 valid  output  1  phase/wrap carry a new step result this cycle.
REQ-011 wrap  output  1  the step shown overflowed 2^W.

Function
REQ-012 W SHALL be an integer multiple of SEG, with SEG >= 1; any other combination is a configuration error flagged at elaboration.
REQ-013 A step is any cycle with en=1 or clr=1; fcw, init, en and clr SHALL all be captured in that cycle, with no input hold requirement afterwards.
REQ-014 Segment k (bits k*SEG+SEG-1 : k*SEG, k = 0..NSEG-1) SHALL process a step k cycles after capture; input skew registers delay fcw/init slice k, en and clr by k cycles.
REQ-015 Segment k SHALL add using the registered carry-out that segment k-1 produced for the same step; segment 0 uses carry-in 0.
REQ-016 A segment's accumulator and carry register SHALL update only when its delayed step qualifier is active; otherwise both hold.
REQ-017 Output deskew registers SHALL delay segment k by NSEG-1-k cycles, so phase, valid and wrap for a step captured at cycle t appear at cycle t+NSEG.
REQ-018 Step with en=1, clr=0: phase = (P + fcw) mod 2^W, where P is the previous step result; wrap = carry-out of segment NSEG-1.
REQ-019 Step with clr=1 (en ignored; clr has priority): phase = init, wrap = 0.
REQ-020 valid SHALL be high exactly NSEG cycles after each step and low otherwise.
REQ-021 On cycles with valid=0, phase SHALL hold the last valid result and wrap SHALL be 0.
REQ-022 Back-to-back steps SHALL sustain throughput of one step per cycle; each step uses only its own fcw sample, with no mixing of adjacent words across segments.
REQ-023 With NSEG=1 the block SHALL degenerate to a single registered accumulator with latency 1.

Reset
REQ-024 reset low SHALL immediately clear all accumulators, carries, skew and deskew registers to 0: phase=0, valid=0, wrap=0.
REQ-025 After reset release with no clr, the first en step SHALL accumulate from P=0.
REQ-026 Steps in flight when reset asserts SHALL be discarded, with no valid produced for them after release.

Verification (W=16, SEG=4, NSEG=4, latency 4)
REQ-027 Release reset, then one cycle of clr=1 with init=0x1234 at cycle c -> at cycle c+4: valid=1, phase=0x1234, wrap=0; cycle c+5: valid=0, phase=0x1234.
REQ-028 From P=0x1234, en=1 with fcw=0x0001 for 3 consecutive cycles -> valid=1 on 3 consecutive cycles with phase 0x1235, 0x1236, 0x1237.
REQ-029 Carry ripple: P=0x0FFF, fcw=0x0001 -> phase 0x1000, wrap=0; next step P=0xFFFF, fcw=0x0001 -> phase 0x0000, wrap=1.
REQ-030 From P=0, fcw alternating 0x0F00, 0x0100, 0x00FF on consecutive steps -> phase 0x0F00, 0x1000, 0x10FF in consecutive cycles.
REQ-031 en pattern 1,0,1 with fcw=0x0010 from P=0x0000 -> valid 1,0,1; phase 0x0010, 0x0010 (held), 0x0020.
REQ-032 Reset asserted 2 cycles after an en step -> phase=0, valid=0 the same cycle; no valid pulse after release until a new step.
